// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the hazard scoreboard.
package hazard_pkg;

  localparam int unsigned NREG_DEFAULT  = 32;
  localparam int unsigned NRD_DEFAULT   = 2;
  localparam int unsigned DEPTH_DEFAULT = 3;

  // Widest register index an entry can hold (NREG up to 256); narrower
  // indices are zero-extended on entry.
  localparam int unsigned WSEL_W = 8;

  // Forward select meaning "take the register file value".
  localparam int unsigned FWD_REGFILE = 0;

  typedef struct packed {
    logic              valid;
    logic [WSEL_W-1:0] wsel;
    logic              is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between the ID stage (master) and the scoreboard (slave).
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int unsigned NREG  = NREG_DEFAULT,
  parameter int unsigned NRD   = NRD_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) ();

  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned FW = $clog2(DEPTH);

  logic              advance;
  logic              issue_valid;
  logic [NRD*RW-1:0] issue_rs;
  logic [NRD-1:0]    issue_rd_en;
  logic              issue_wr_en;
  logic [RW-1:0]     issue_wsel;
  logic              issue_is_load;
  logic              flush;
  logic              stall;
  logic [NRD*FW-1:0] fwd_ex;
  logic [31:0]       stall_cnt;

  modport master (
    output advance, issue_valid, issue_rs, issue_rd_en, issue_wr_en,
           issue_wsel, issue_is_load, flush,
    input  stall, fwd_ex, stall_cnt
  );

  modport slave (
    input  advance, issue_valid, issue_rs, issue_rd_en, issue_wr_en,
           issue_wsel, issue_is_load, flush,
    output stall, fwd_ex, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// sb_match: compares one read port against every in-flight entry and
// reports the hit vector plus the youngest hit among stages that can stall
// or forward (WB is excluded: the register file writes through).
module sb_match
  import hazard_pkg::*;
#(
  parameter  int unsigned NREG  = NREG_DEFAULT,
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned RW    = $clog2(NREG),
  localparam int unsigned FW    = $clog2(DEPTH)
) (
  input  logic                  rd_en,
  input  logic [RW-1:0]         rs,
  input  sb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      hit,
  output logic                  found,
  output logic [FW-1:0]         youngest
);

  // Per-stage match; register 0 never matches.
  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      hit[k] = rd_en && entries[k].valid &&
               (entries[k].wsel == WSEL_W'(rs)) && (rs != '0);
    end
  end

  // Lowest matching stage below WB.
  always_comb begin
    found    = 1'b0;
    youngest = '0;
    for (int unsigned k = 0; k < DEPTH - 1; k++) begin
      if (hit[k] && !found) begin
        found    = 1'b1;
        youngest = FW'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destination registers from EX to WB,
// raises stall on unresolvable RAW hazards and produces registered forward
// selects for the instruction entering EX.
// Optional feature macro: HAZARD_FORWARDING_EN (load-use stalls only, with
// forwarding); undefined means stall on any RAW hazard, no forwarding.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG  = NREG_DEFAULT,
  parameter int unsigned NRD   = NRD_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input logic                CLK,
  input logic                RST,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned FW = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0]       pipe_q;
  sb_entry_t                   issue_entry;
  logic [NRD-1:0][DEPTH-1:0]   hit;
  logic [NRD-1:0]              found;
  logic [NRD-1:0][FW-1:0]      youngest;
  logic                        hazard;
  logic                        stall_w;
  logic                        insert;
  logic [31:0]                 cnt_q;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    sb_match #(.NREG(NREG), .DEPTH(DEPTH)) u_match (
      .rd_en    (bus.issue_rd_en[p]),
      .rs       (bus.issue_rs[p*RW +: RW]),
      .entries  (pipe_q),
      .hit      (hit[p]),
      .found    (found[p]),
      .youngest (youngest[p])
    );
  end

  // Hazard rule: load-use only when forwarding, any live producer otherwise.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned p = 0; p < NRD; p++) begin
`ifdef HAZARD_FORWARDING_EN
      if (found[p] && (youngest[p] == '0) && pipe_q[0].is_load) hazard = 1'b1;
`else
      if (found[p]) hazard = 1'b1;
`endif
    end
  end

  assign stall_w   = bus.issue_valid && !bus.flush && hazard;
  assign insert    = bus.issue_valid && !stall_w && !bus.flush;
  assign bus.stall = stall_w;

  // Entry presented by ID; only a writing instruction occupies a live slot.
  always_comb begin
    issue_entry         = '0;
    issue_entry.valid   = bus.issue_wr_en;
    issue_entry.wsel    = WSEL_W'(bus.issue_wsel);
    issue_entry.is_load = bus.issue_is_load;
  end

  // In-flight pipe: shift on advance, bubble into EX unless an instruction issues.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe_q <= '0;
    end else if (bus.advance) begin
      for (int unsigned k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
      pipe_q[0] <= insert ? issue_entry : '0;
    end
  end

`ifdef HAZARD_FORWARDING_EN
  logic [NRD*FW-1:0] fwd_q;
  logic              unused_hit;

  // Forward select k+1 points at the latch after stage k; 0 is the register file.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fwd_q <= '0;
    end else if (bus.advance) begin
      for (int unsigned p = 0; p < NRD; p++) begin
        fwd_q[p*FW +: FW] <= (insert && found[p]) ? youngest[p] + FW'(1)
                                                  : FW'(FWD_REGFILE);
      end
    end
  end

  assign bus.fwd_ex = fwd_q;
  assign unused_hit = ^hit;
`else
  logic unused_match;

  assign bus.fwd_ex   = '0;
  assign unused_match = ^{hit, youngest};
`endif

  // Saturating count of cycles where the pipe advanced while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (bus.advance && stall_w && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = cnt_q;

endmodule
